multdiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS core's execute stage. Accepts one MULT/MULTU/DIV/DIVU operation (encoded as `multicycle_t`) with two `word_t` operands and returns HI/LO results as a pair of `hilo_write_req` packets, which the writeback stage applies to the HI/LO registers. Execute holds the instruction while `busy` is high. The unit supports abort via `flush` on exception or redirect.

---
 rtl/multdiv_unit.sv | 138 +++++++++++++
 tb/tb_multdiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative MIPS multiply/divide unit: pipelined multiply, radix-2 restoring divide.
// hi_write/lo_write pack a hilo_write_req as {valid, data[31:0]}; op encodes multicycle_t.
module multdiv_unit #(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [32:0] hi_write,
  output logic [32:0] lo_write
);

  localparam logic [1:0] M_MULT  = 2'd0;
  localparam logic [1:0] M_MULTU = 2'd1;
  localparam logic [1:0] M_DIV   = 2'd2;
  localparam logic [1:0] M_DIVU  = 2'd3;
  localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic        accept;
  logic [31:0] hi_data, lo_data;

  logic [63:0] mul_p [MUL_STAGES];
  logic [1:0]  op_q;
  logic [31:0] a_q, dvs, quo, rem;
  logic        a_neg, b_neg, div0;
  logic [32:0] shifted, diff;
  logic        q_bit;
  logic [31:0] rem_next, quo_next;

  function automatic logic [63:0] mul_full(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
    logic signed [32:0] xs, ys;
    logic signed [63:0] xe, ye;
    xs = {sgn & x[31], x};
    ys = {sgn & y[31], y};
    xe = 64'(xs);
    ye = 64'(ys);
    return xe * ye;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? 32'(0 - x) : x;
  endfunction

  // Returns {hi, lo}; the zero-divisor case overrides the iterative result.
  function automatic logic [63:0] div_fix(input logic [31:0] q, input logic [31:0] r,
                                          input logic sgn, input logic an, input logic bn,
                                          input logic zero, input logic [31:0] araw);
    logic [31:0] qf, rf;
    qf = (sgn && (an != bn)) ? 32'(0 - q) : q;
    rf = (sgn && an) ? 32'(0 - r) : r;
    return zero ? {araw, 32'hFFFF_FFFF} : {rf, qf};
  endfunction

  assign ready    = !busy;
  assign accept   = valid && ready && !flush;
  assign done     = (state == DONE) && !flush;
  assign hi_write = {done, hi_data};
  assign lo_write = {done, lo_data};

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = op[1] ? DIV : MUL;
      MUL:  if (cnt == MUL_LAST) state_next = DONE;
      DIV:  if (cnt == DIV_LAST) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    shifted  = {rem, quo[31]};
    diff     = shifted - {1'b0, dvs};
    q_bit    = !diff[32];
    rem_next = q_bit ? diff[31:0] : shifted[31:0];
    quo_next = {quo[30:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= 6'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      cnt   <= ((state == MUL || state == DIV) && state_next == state) ? cnt + 6'd1 : 6'd0;
    end
  end

  // Result registers update only on the last MUL/DIV edge of an unflushed operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_data <= 32'd0;
      lo_data <= 32'd0;
    end else if (!flush) begin
      if (state == MUL && cnt == MUL_LAST)
        {hi_data, lo_data} <= mul_p[MUL_STAGES-1];
      else if (state == DIV && cnt == DIV_LAST)
        {hi_data, lo_data} <= div_fix(quo_next, rem_next, op_q == M_DIV, a_neg, b_neg,
                                      div0, a_q);
    end
  end

  // Datapath stage p0: operands captured on accept, product enters the pipeline.
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_p[0] <= mul_full(a, b, op == M_MULT);
      op_q     <= op;
      a_q      <= a;
      a_neg    <= a[31];
      b_neg    <= b[31];
      div0     <= (b == 32'd0);
      dvs      <= mag(b, op == M_DIV);
      quo      <= mag(a, op == M_DIV);
      rem      <= 32'd0;
    end else if (state == DIV) begin
      rem <= rem_next;
      quo <= quo_next;
    end
    for (int i = 1; i < MUL_STAGES; i++) mul_p[i] <= mul_p[i-1];
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit with hand-computed HI/LO results.
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        reset, valid, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        ready, busy, done;
  logic [32:0] hi_write, lo_write;
  int          checks = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          n0;

  localparam logic [1:0] M_MULT = 2'd0, M_MULTU = 2'd1, M_DIV = 2'd2, M_DIVU = 2'd3;

  multdiv_unit #(.MUL_STAGES(2)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b), .flush(flush),
    .ready(ready), .busy(busy), .done(done), .hi_write(hi_write), .lo_write(lo_write)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns #1 after the accept edge (T+1).
  task automatic start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    valid = 1'b1; op = o; a = x; b = y;
    tick(1);
    valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; valid = 1'b0; flush = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    tick(2);
    reset = 1'b0;
    checks++; if ({ready, busy, done} !== 3'b100) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 100", {ready, busy, done}); end
    checks++; if (hi_write !== 33'h0) begin
      fails++; $display("FAIL reset_hi: got %h expected 0", hi_write); end
    checks++; if (lo_write !== 33'h0) begin
      fails++; $display("FAIL reset_lo: got %h expected 0", lo_write); end
  endtask

  task automatic test_mult;
    start(M_MULT, 32'hFFFF_FFFF, 32'd2);
    tick(1);
    checks++; if (done !== 1'b0) begin
      fails++; $display("FAIL mult_early: got done=%b expected 0", done); end
    tick(1);
    checks++; if (done !== 1'b1) begin
      fails++; $display("FAIL mult_done: got %b expected 1", done); end
    checks++; if (hi_write !== 33'h1_FFFF_FFFF) begin
      fails++; $display("FAIL mult_hi: got %h expected 1ffffffff", hi_write); end
    checks++; if (lo_write !== 33'h1_FFFF_FFFE) begin
      fails++; $display("FAIL mult_lo: got %h expected 1fffffffe", lo_write); end
    tick(1);
    checks++; if ({ready, busy, done} !== 3'b100) begin
      fails++; $display("FAIL mult_after: got %b expected 100", {ready, busy, done}); end
    checks++; if (hi_write !== 33'h0_FFFF_FFFF) begin
      fails++; $display("FAIL mult_hold: got %h expected 0ffffffff", hi_write); end
    start(M_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick(2);
    checks++; if (hi_write !== 33'h1_0000_0001) begin
      fails++; $display("FAIL multu_hi: got %h expected 100000001", hi_write); end
    checks++; if (lo_write !== 33'h1_FFFF_FFFE) begin
      fails++; $display("FAIL multu_lo: got %h expected 1fffffffe", lo_write); end
    tick(1);
  endtask

  task automatic test_div;
    start(M_DIV, 32'hFFFF_FFF9, 32'd2);
    tick(31);
    checks++; if (done !== 1'b0) begin
      fails++; $display("FAIL div_early: got done=%b expected 0", done); end
    tick(1);
    checks++; if (lo_write !== 33'h1_FFFF_FFFD) begin
      fails++; $display("FAIL div_lo: got %h expected 1fffffffd", lo_write); end
    checks++; if (hi_write !== 33'h1_FFFF_FFFF) begin
      fails++; $display("FAIL div_hi: got %h expected 1ffffffff", hi_write); end
    tick(1);
    start(M_DIVU, 32'd100, 32'd7);
    tick(32);
    checks++; if (lo_write !== 33'h1_0000_000E) begin
      fails++; $display("FAIL divu_lo: got %h expected 10000000e", lo_write); end
    checks++; if (hi_write !== 33'h1_0000_0002) begin
      fails++; $display("FAIL divu_hi: got %h expected 100000002", hi_write); end
    tick(1);
  endtask

  task automatic test_div_corner;
    start(M_DIVU, 32'h1234_5678, 32'd0);
    tick(32);
    checks++; if (done !== 1'b1) begin
      fails++; $display("FAIL div0_done: got %b expected 1", done); end
    checks++; if (lo_write !== 33'h1_FFFF_FFFF) begin
      fails++; $display("FAIL div0_lo: got %h expected 1ffffffff", lo_write); end
    checks++; if (hi_write !== 33'h1_1234_5678) begin
      fails++; $display("FAIL div0_hi: got %h expected 112345678", hi_write); end
    tick(1);
    start(M_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(32);
    checks++; if (lo_write !== 33'h1_8000_0000) begin
      fails++; $display("FAIL divovf_lo: got %h expected 180000000", lo_write); end
    checks++; if (hi_write !== 33'h1_0000_0000) begin
      fails++; $display("FAIL divovf_hi: got %h expected 100000000", hi_write); end
    tick(1);
    start(M_DIV, 32'hFFFF_FFFB, 32'd0);
    tick(32);
    checks++; if (lo_write !== 33'h1_FFFF_FFFF) begin
      fails++; $display("FAIL sdiv0_lo: got %h expected 1ffffffff", lo_write); end
    checks++; if (hi_write !== 33'h1_FFFF_FFFB) begin
      fails++; $display("FAIL sdiv0_hi: got %h expected 1fffffffb", hi_write); end
    tick(1);
  endtask

  task automatic test_flush;
    n0 = done_cnt;
    start(M_DIV, 32'd1000, 32'd3);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++; if ({ready, busy, done} !== 3'b100) begin
      fails++; $display("FAIL flush_idle: got %b expected 100", {ready, busy, done}); end
    start(M_MULT, 32'd7, 32'hFFFF_FFFD);
    tick(2);
    checks++; if (hi_write !== 33'h1_FFFF_FFFF) begin
      fails++; $display("FAIL flush_mult_hi: got %h expected 1ffffffff", hi_write); end
    checks++; if (lo_write !== 33'h1_FFFF_FFEB) begin
      fails++; $display("FAIL flush_mult_lo: got %h expected 1ffffffeb", lo_write); end
    tick(1);
    checks++; if (done_cnt - n0 !== 1) begin
      fails++; $display("FAIL flush_pulses: got %0d expected 1", done_cnt - n0); end
    valid = 1'b1; flush = 1'b1; op = M_MULT;
    tick(1);
    valid = 1'b0; flush = 1'b0;
    checks++; if ({ready, busy} !== 2'b10) begin
      fails++; $display("FAIL flush_noaccept: got %b expected 10", {ready, busy}); end
    tick(4);
    checks++; if (done_cnt - n0 !== 1) begin
      fails++; $display("FAIL flush_nodone: got %0d expected 1", done_cnt - n0); end
  endtask

  task automatic test_reset_mid;
    n0 = done_cnt;
    start(M_DIV, 32'd50, 32'd5);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if ({ready, busy, done} !== 3'b100) begin
      fails++; $display("FAIL rmid_ctrl: got %b expected 100", {ready, busy, done}); end
    checks++; if (hi_write !== 33'h0 || lo_write !== 33'h0) begin
      fails++; $display("FAIL rmid_data: got %h %h expected 0 0", hi_write, lo_write); end
    tick(40);
    checks++; if (done_cnt !== n0) begin
      fails++; $display("FAIL rmid_nodone: got %0d expected %0d", done_cnt, n0); end
  endtask

  task automatic test_valid_busy;
    n0 = done_cnt;
    start(M_DIVU, 32'd100, 32'd7);
    tick(3);
    valid = 1'b1; op = M_MULT; a = 32'd3; b = 32'd5;
    tick(1);
    valid = 1'b0;
    tick(28);
    checks++; if (lo_write !== 33'h1_0000_000E || hi_write !== 33'h1_0000_0002) begin
      fails++; $display("FAIL vbusy_result: got %h %h expected 10000000e 100000002",
                        lo_write, hi_write); end
    tick(6);
    checks++; if (done_cnt - n0 !== 1) begin
      fails++; $display("FAIL vbusy_pulses: got %0d expected 1", done_cnt - n0); end
    checks++; if (lo_write !== 33'h0_0000_000E) begin
      fails++; $display("FAIL vbusy_hold: got %h expected 00000000e", lo_write); end
  endtask

  task automatic test_back_to_back;
    start(M_MULT, 32'h8000_0000, 32'h8000_0000);
    tick(2);
    checks++; if (hi_write !== 33'h1_4000_0000 || lo_write !== 33'h1_0000_0000) begin
      fails++; $display("FAIL b2b_first: got %h %h expected 140000000 100000000",
                        hi_write, lo_write); end
    tick(1);
    checks++; if (ready !== 1'b1) begin
      fails++; $display("FAIL b2b_ready: got %b expected 1", ready); end
    start(M_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(2);
    checks++; if (hi_write !== 33'h1_FFFF_FFFE || lo_write !== 33'h1_0000_0001) begin
      fails++; $display("FAIL b2b_second: got %h %h expected 1fffffffe 100000001",
                        hi_write, lo_write); end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_flush();
    test_reset_mid();
    test_valid_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
